// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, sizes and key numbering for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} scan_state_t;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
    return 4'(row * NUM_COLS + col);
  endfunction

endpackage

// File: rtl/col_sync.sv
// rtl/col_sync.sv - two-flop synchronizer for asynchronous column inputs, resets to all-ones
module col_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scanner with debounced one-hot key and press strobe
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 50000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  cols,
  output logic [3:0]  rows,
  output logic [15:0] key,
  output logic [3:0]  keyCode,
  output logic        keyPress
);

  localparam int DW = $clog2(SCAN_CYCLES) + 1;
  localparam int BW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);

  scan_state_t state, state_n;
  logic [3:0]    cols_s;
  logic [DW-1:0] dwell, dwell_n;
  logic [BW-1:0] db, db_n;
  logic [1:0]    row_idx, row_idx_n;
  logic [1:0]    cap_col, cap_col_n;
  logic [3:0]    cap_pat, cap_pat_n;
  logic [15:0]   key_n;
  logic [3:0]    code_n;
  logic          press_n;
  logic [3:0]    low;
  logic          one_low;
  logic [1:0]    low_col;

  col_sync #(.WIDTH(NUM_COLS)) u_col_sync (
    .clk   (clk),
    .reset (reset),
    .d     (cols),
    .q     (cols_s)
  );

  assign low     = ~cols_s;
  assign one_low = (low != 4'h0) && ((low & (low - 4'h1)) == 4'h0);

  always_comb begin
    low_col = 2'd0;
    for (int c = NUM_COLS - 1; c >= 0; c--) begin
      if (low[c]) low_col = 2'(c);
    end
  end

  // row_idx is frozen outside SCAN, so it doubles as the captured row.
  always_comb begin
    state_n   = state;
    dwell_n   = dwell;
    db_n      = db;
    row_idx_n = row_idx;
    cap_col_n = cap_col;
    cap_pat_n = cap_pat;
    key_n     = key;
    code_n    = keyCode;
    press_n   = 1'b0;
    case (state)
      SCAN: begin
        if (dwell == DWELL_LAST) begin
          dwell_n = '0;
          if (one_low) begin
            state_n   = DEBOUNCE;
            db_n      = '0;
            cap_pat_n = cols_s;
            cap_col_n = low_col;
          end else begin
            row_idx_n = row_idx + 2'd1;
          end
        end else begin
          dwell_n = dwell + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (cols_s != cap_pat) begin
          state_n = SCAN;
          dwell_n = '0;
        end else if (db == DB_LAST) begin
          state_n = HELD;
          db_n    = '0;
          key_n   = 16'h0001 << key_index(row_idx, cap_col);
          code_n  = key_index(row_idx, cap_col);
          press_n = 1'b1;
        end else begin
          db_n = db + 1'b1;
        end
      end
      HELD: begin
        if (cols_s == 4'hF) begin
          state_n = RELEASE;
          db_n    = '0;
        end
      end
      RELEASE: begin
        if (!cols_s[cap_col]) begin
          state_n = HELD;
          db_n    = '0;
        end else if (cols_s != 4'hF) begin
          db_n = '0;
        end else if (db == DB_LAST) begin
          state_n   = SCAN;
          key_n     = '0;
          row_idx_n = row_idx + 2'd1;
          dwell_n   = '0;
        end else begin
          db_n = db + 1'b1;
        end
      end
      default: state_n = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SCAN;
      dwell    <= '0;
      db       <= '0;
      row_idx  <= 2'd0;
      cap_col  <= 2'd0;
      cap_pat  <= 4'hF;
      rows     <= 4'b1110;
      key      <= 16'h0000;
      keyCode  <= 4'h0;
      keyPress <= 1'b0;
    end else begin
      state    <= state_n;
      dwell    <= dwell_n;
      db       <= db_n;
      row_idx  <= row_idx_n;
      cap_col  <= cap_col_n;
      cap_pat  <= cap_pat_n;
      rows     <= ~(4'b0001 << row_idx_n);
      key      <= key_n;
      keyCode  <= code_n;
      keyPress <= press_n;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench: keypad matrix model, reference model, directed and random tests
module tb_keypad_scanner;

  localparam int SCAN = 4;
  localparam int DB   = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  cols = 4'hF;
  logic [3:0]  rows;
  logic [15:0] key;
  logic [3:0]  keyCode;
  logic        keyPress;

  keypad_scanner #(.SCAN_CYCLES(SCAN), .DEBOUNCE_CYCLES(DB)) dut (
    .clk      (clk),
    .reset    (reset),
    .cols     (cols),
    .rows     (rows),
    .key      (key),
    .keyCode  (keyCode),
    .keyPress (keyPress)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          press_cnt = 0;
  logic [15:0] pressed = 16'h0;
  logic        glitch_high = 1'b0;
  logic        check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Physical keypad: a column reads low when a pressed key sits on a driven row.
  function automatic logic [3:0] matrix(input logic [3:0] r, input logic [15:0] p);
    logic [3:0] c = 4'hF;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (r[i] === 1'b0 && p[i*4+j]) c[j] = 1'b0;
    return c;
  endfunction

  // Reference model: phases are tracked by the cycle number at which their count was zero.
  localparam int M_SCAN = 0, M_DB = 1, M_HELD = 2, M_REL = 3;
  int          cyc = 0;
  int          m_mode = M_SCAN, m_row = 0, m_t0 = 0, m_col = 0;
  logic [3:0]  m_s0 = 4'hF, m_s1 = 4'hF, m_cap = 4'hF;
  logic [15:0] m_key = 16'h0;
  logic [3:0]  m_code = 4'h0;
  logic        m_press = 1'b0;

  always @(posedge clk) begin
    logic [3:0] cs;
    if (reset) begin
      m_mode = M_SCAN; m_row = 0; m_t0 = cyc + 1; m_s0 = 4'hF; m_s1 = 4'hF;
      m_key = 16'h0; m_code = 4'h0; m_press = 1'b0; m_cap = 4'hF;
    end else begin
      cs = m_s1; m_s1 = m_s0; m_s0 = cols;
      m_press = 1'b0;
      case (m_mode)
        M_SCAN:
          if (cyc - m_t0 == SCAN - 1) begin
            m_t0 = cyc + 1;
            if ($countones(~cs) == 1) begin
              m_mode = M_DB; m_cap = cs;
              for (int j = 0; j < 4; j++) if (!cs[j]) m_col = j;
            end else begin
              m_row = (m_row + 1) % 4;
            end
          end
        M_DB:
          if (cs != m_cap) begin
            m_mode = M_SCAN; m_t0 = cyc + 1;
          end else if (cyc - m_t0 == DB - 1) begin
            m_mode = M_HELD;
            m_code = 4'(m_row * 4 + m_col);
            m_key = 16'h0; m_key[m_row*4+m_col] = 1'b1;
            m_press = 1'b1;
          end
        M_HELD:
          if (cs == 4'hF) begin
            m_mode = M_REL; m_t0 = cyc + 1;
          end
        default:
          if (!cs[m_col]) m_mode = M_HELD;
          else if (cs != 4'hF) m_t0 = cyc + 1;
          else if (cyc - m_t0 == DB - 1) begin
            m_mode = M_SCAN; m_key = 16'h0; m_row = (m_row + 1) % 4; m_t0 = cyc + 1;
          end
      endcase
    end
    cyc++;
  end

  always @(negedge clk) begin
    logic [3:0] exp_rows;
    if (check_en) begin
      exp_rows = ~(4'b0001 << m_row);
      check($sformatf("cycle%0d rows/key/code/press", cyc),
            {7'h0, rows, key, keyCode, keyPress},
            {7'h0, exp_rows, m_key, m_code, m_press});
    end
    if (keyPress === 1'b1) press_cnt++;
    cols = glitch_high ? 4'hF : matrix(rows, pressed);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_mode(input int mode, input int budget, input string name);
    int n = 0;
    while (m_mode != mode && n < budget) begin
      tick(1);
      n++;
    end
    if (m_mode != mode) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout after %0d cycles, phase %0d required %0d", name, n, m_mode, mode);
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    glitch_high = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " rows"}, rows, 4'b1110);
    check({name, " key"}, key, 16'h0);
    check({name, " keyCode"}, keyCode, 4'h0);
    check({name, " keyPress"}, keyPress, 1'b0);
  endtask

  typedef struct {
    int          row;
    int          col;
    logic [15:0] exp_key;
    logic [3:0]  exp_code;
  } vec_t;

  vec_t vecs[6];
  int   p0;
  int   first_k;
  logic [3:0] exp_r;

  initial begin
    vecs[0] = '{1, 2, 16'h0040, 4'h6};
    vecs[1] = '{0, 0, 16'h0001, 4'h0};
    vecs[2] = '{3, 3, 16'h8000, 4'hF};
    vecs[3] = '{2, 1, 16'h0200, 4'h9};
    vecs[4] = '{0, 3, 16'h0008, 4'h3};
    vecs[5] = '{3, 0, 16'h1000, 4'hC};

    // Reset held three cycles, then rows walk one step every SCAN cycles.
    reset = 1'b1;
    tick(1);
    check_en = 1'b1;
    tick(2);
    check_reset_outputs("reset");
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      exp_r = ~(4'b0001 << ((k / 4) % 4));
      check($sformatf("scan step %0d rows", k), rows, exp_r);
    end

    // Clean press on row 1 col 2: sampled at count 7, strobe 9 cycles later.
    tick(1);
    reset_dut();
    pressed = 16'h0040;
    p0 = press_cnt;
    first_k = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (keyPress === 1'b1 && first_k < 0) first_k = k;
    end
    check("clean press strobe cycle", first_k, 16);
    check("clean press key", key, 16'h0040);
    check("clean press keyCode", keyCode, 4'h6);
    check("clean press strobe count", press_cnt - p0, 1);
    tick(1);
    pressed = 16'h0;
    for (int k = 0; k < 40 && key !== 16'h0; k++) @(negedge clk);
    check("clean release key", key, 16'h0);
    check("clean release resume row", rows, 4'b1011);

    // Table of single-key presses.
    foreach (vecs[i]) begin
      tick(1);
      reset_dut();
      pressed = 16'h0;
      pressed[vecs[i].row*4+vecs[i].col] = 1'b1;
      p0 = press_cnt;
      tick(60);
      check($sformatf("vec%0d key", i), key, vecs[i].exp_key);
      check($sformatf("vec%0d keyCode", i), keyCode, vecs[i].exp_code);
      check($sformatf("vec%0d strobes", i), press_cnt - p0, 1);
      pressed = 16'h0;
      tick(40);
      check($sformatf("vec%0d released key", i), key, 16'h0);
      check($sformatf("vec%0d held code", i), keyCode, vecs[i].exp_code);
    end

    // Bounce during press debounce aborts, then a stable press is accepted once.
    reset_dut();
    pressed = 16'h0001;
    p0 = press_cnt;
    wait_mode(M_DB, 100, "bounce press debounce");
    tick(3);
    pressed = 16'h0;
    tick(1);
    pressed = 16'h0001;
    tick(3);
    check("bounce press no strobe", press_cnt - p0, 0);
    check("bounce press key", key, 16'h0);
    tick(60);
    check("bounce press final key", key, 16'h0001);
    check("bounce press strobes", press_cnt - p0, 1);

    // Short release bounce returns to HELD without a second strobe.
    reset_dut();
    pressed = 16'h8000;
    p0 = press_cnt;
    wait_mode(M_HELD, 100, "bounce release held");
    tick(5);
    pressed = 16'h0;
    tick(3);
    pressed = 16'h8000;
    tick(20);
    check("bounce release key", key, 16'h8000);
    check("bounce release strobes", press_cnt - p0, 1);
    pressed = 16'h0;
    tick(30);
    check("bounce release cleared", key, 16'h0);

    // Two keys on one row are ignored; an extra column while held is ignored.
    reset_dut();
    pressed = 16'h3000;
    p0 = press_cnt;
    tick(50);
    check("multi key ignored", key, 16'h0);
    check("multi key strobes", press_cnt - p0, 0);
    pressed = 16'h0001;
    wait_mode(M_HELD, 100, "multi held");
    pressed = 16'h0003;
    tick(20);
    check("held extra col key", key, 16'h0001);
    check("held extra col code", keyCode, 4'h0);
    check("held extra col strobes", press_cnt - p0, 1);
    pressed = 16'h0;
    tick(30);

    // Reset during DEBOUNCE and during HELD.
    reset_dut();
    pressed = 16'h0020;
    p0 = press_cnt;
    wait_mode(M_DB, 100, "reset mid debounce");
    tick(2);
    reset = 1'b1;
    tick(1);
    check_reset_outputs("reset in debounce");
    check("reset in debounce strobes", press_cnt - p0, 0);
    reset = 1'b0;
    wait_mode(M_HELD, 100, "reset mid held");
    tick(3);
    reset = 1'b1;
    tick(1);
    check_reset_outputs("reset in held");
    reset = 1'b0;
    pressed = 16'h0;
    tick(10);

    // Random presses, releases, chords, glitches and resets against the model.
    for (int it = 0; it < 250; it++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 10) begin
        pressed = 16'h0;
        pressed[$urandom_range(0, 15)] = 1'b1;
      end else if (r < 14) begin
        pressed = 16'h0;
      end else if (r < 16) begin
        pressed[$urandom_range(0, 15)] = 1'b1;
      end else if (r < 19) begin
        glitch_high = 1'b1;
        tick($urandom_range(1, 3));
        glitch_high = 1'b0;
      end else begin
        reset = 1'b1;
        tick($urandom_range(1, 2));
        reset = 1'b0;
      end
      tick($urandom_range(1, 40));
    end

    pressed = 16'h0;
    tick(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
